// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_fsm_if.sv
// Request/result bundle between a client and the bit-serial adder.
interface serial_adder_fsm_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             bit_valid;
    logic             sum_bit;
    logic             carry_bit;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, overflow, bit_valid, sum_bit, carry_bit
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, overflow, bit_valid, sum_bit, carry_bit
    );

endinterface

// File: rtl/serial_adder_fsm_full_adder_cell.sv
// One-bit combinational full adder used for every serial bit step.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, carry held as state.
module serial_adder_fsm
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_adder_fsm_if.slave bus
);

    localparam int                 IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] sum_q;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             s;
    logic             c_next;
    logic             running;
    logic             accept;
    logic             last_bit;

    full_adder_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_q),
        .s    (s),
        .cout (c_next)
    );

    assign running  = (state == RUN);
    assign accept   = bus.start && !running;
    assign last_bit = running && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Start is ignored while running, so operands are only sampled on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            sum_q   <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_sr    <= bus.a;
            b_sr    <= (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
            carry_q <= (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;
            idx     <= '0;
        end else if (running) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            res_sr  <= {s, res_sr[WIDTH-1:1]};
            carry_q <= c_next;
            if (!last_bit) begin
                idx <= idx + 1'b1;
            end else begin
                // carry_q here is the carry into the MSB, c_next the carry out of it.
                sum_q  <= {s, res_sr[WIDTH-1:1]};
                cout_q <= c_next;
                ovf_q  <= carry_q ^ c_next;
            end
        end
    end

    assign bus.busy      = running;
    assign bus.done      = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.bit_valid = running;
    assign bus.sum_bit   = running & s;
    assign bus.carry_bit = running & c_next;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed self-checking bench for the 8-bit serial adder/subtractor.
module tb_serial_adder_fsm;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    serial_adder_fsm_if #(.WIDTH(8)) sif ();

    serial_adder_fsm #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
        $fatal(1);
    end

    // Launch one operation and collect the observed result, latency and serial stream.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tsub,
                         input logic tcin, output logic [7:0] osum, output logic ocout,
                         output logic oovf, output int ocyc, output int onvalid,
                         output logic [7:0] oser, output logic olast_carry);
        @(negedge clk);
        sif.start = 1'b1;
        sif.a     = ta;
        sif.b     = tb_v;
        sif.sub   = tsub;
        sif.cin   = tcin;
        @(negedge clk);
        sif.start   = 1'b0;
        ocyc        = 0;
        onvalid     = 0;
        oser        = '0;
        olast_carry = 1'b0;
        while (!sif.done && ocyc < 20) begin
            if (sif.bit_valid) begin
                if (onvalid < 8) oser[onvalid] = sif.sum_bit;
                olast_carry = sif.carry_bit;
                onvalid++;
            end
            @(negedge clk);
            ocyc++;
        end
        osum  = sif.sum;
        ocout = sif.cout;
        oovf  = sif.overflow;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        sif.start = 1'b0;
        sif.sub   = 1'b0;
        sif.a     = '0;
        sif.b     = '0;
        sif.cin   = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({sif.busy, sif.done, sif.sum, sif.cout, sif.overflow, sif.bit_valid,
             sif.sum_bit, sif.carry_bit} !== 15'h0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b ovf=%b bv=%b sb=%b cb=%b required all 0",
                     sif.busy, sif.done, sif.sum, sif.cout, sif.overflow, sif.bit_valid,
                     sif.sum_bit, sif.carry_bit);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_basic();
        logic [7:0] s, ser;
        logic       c, v, lc;
        int         cyc, nv;
        do_op(8'h3C, 8'h0F, 1'b0, 1'b0, s, c, v, cyc, nv, ser, lc);
        tests++;
        if (s !== 8'h4B) begin fails++; $display("FAIL add_basic_sum: got %h required 4b", s); end
        tests++;
        if ({c, v} !== 2'b00) begin fails++; $display("FAIL add_basic_flags: cout/ovf got %b%b required 00", c, v); end
        tests++;
        if (cyc !== 8) begin fails++; $display("FAIL add_basic_latency: done after %0d cycles required 8", cyc); end
        tests++;
        if (nv !== 8) begin fails++; $display("FAIL add_basic_bit_valid: high %0d cycles required 8", nv); end
        tests++;
        if (ser !== 8'h4B) begin fails++; $display("FAIL add_basic_serial: sum_bit stream %h required 4b", ser); end
        tests++;
        if (lc !== 1'b0) begin fails++; $display("FAIL add_basic_last_carry: got %b required 0", lc); end
        @(negedge clk);
        tests++;
        if ({sif.done, sif.busy, sif.sum} !== {2'b00, 8'h4B}) begin
            fails++;
            $display("FAIL add_basic_after: done=%b busy=%b sum=%h required 0 0 4b", sif.done, sif.busy, sif.sum);
        end
    endtask

    task automatic test_add_wrap();
        logic [7:0] va [3] = '{8'hFF, 8'h7F, 8'h00};
        logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h00};
        logic       vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] es [3] = '{8'h00, 8'h80, 8'h01};
        logic [1:0] ef [3] = '{2'b10, 2'b01, 2'b00};
        logic [7:0] s, ser;
        logic       c, v, lc;
        int         cyc, nv;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], 1'b0, vc[i], s, c, v, cyc, nv, ser, lc);
            tests++;
            if (s !== es[i]) begin
                fails++;
                $display("FAIL add_wrap_sum[%0d]: got %h required %h", i, s, es[i]);
            end
            tests++;
            if ({c, v} !== ef[i]) begin
                fails++;
                $display("FAIL add_wrap_flags[%0d]: cout/ovf got %b%b required %b", i, c, v, ef[i]);
            end
            tests++;
            if (lc !== ef[i][1]) begin
                fails++;
                $display("FAIL add_wrap_carry_bit[%0d]: got %b required %b", i, lc, ef[i][1]);
            end
        end
    endtask

    task automatic test_sub();
        logic [7:0] va [2] = '{8'h05, 8'h80};
        logic [7:0] vb [2] = '{8'h07, 8'h01};
        logic       vc [2] = '{1'b1, 1'b0};
        logic [7:0] es [2] = '{8'hFE, 8'h7F};
        logic [1:0] ef [2] = '{2'b00, 2'b11};
        logic [7:0] s, ser;
        logic       c, v, lc;
        int         cyc, nv;
        for (int i = 0; i < 2; i++) begin
            do_op(va[i], vb[i], 1'b1, vc[i], s, c, v, cyc, nv, ser, lc);
            tests++;
            if (s !== es[i]) begin
                fails++;
                $display("FAIL sub_sum[%0d]: got %h required %h", i, s, es[i]);
            end
            tests++;
            if ({c, v} !== ef[i]) begin
                fails++;
                $display("FAIL sub_flags[%0d]: cout/ovf got %b%b required %b", i, c, v, ef[i]);
            end
            tests++;
            if (ser !== es[i]) begin
                fails++;
                $display("FAIL sub_serial[%0d]: sum_bit stream %h required %h", i, ser, es[i]);
            end
        end
    endtask

    task automatic test_start_mid_run();
        int ndone, first_done;
        @(negedge clk);
        sif.start = 1'b1; sif.a = 8'h55; sif.b = 8'h11; sif.sub = 1'b0; sif.cin = 1'b0;
        ndone = 0;
        first_done = -1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (sif.done) begin
                ndone++;
                if (first_done < 0) first_done = cyc;
            end
            if (cyc == 0) sif.start = 1'b0;
            if (cyc == 3) begin
                sif.start = 1'b1; sif.a = 8'hAA; sif.b = 8'hAA; sif.sub = 1'b1; sif.cin = 1'b1;
            end
            if (cyc == 4) sif.start = 1'b0;
        end
        tests++;
        if (ndone !== 1) begin fails++; $display("FAIL mid_run_done_count: got %0d required 1", ndone); end
        tests++;
        if (first_done !== 8) begin fails++; $display("FAIL mid_run_done_cycle: got %0d required 8", first_done); end
        tests++;
        if (sif.sum !== 8'h66) begin fails++; $display("FAIL mid_run_sum: got %h required 66", sif.sum); end
    endtask

    task automatic test_back_to_back();
        int         ndone, bad_pos;
        logic [7:0] exp_res [3] = '{8'h03, 8'h12, 8'h22};
        @(negedge clk);
        sif.start = 1'b1; sif.a = 8'h01; sif.b = 8'h02; sif.sub = 1'b0; sif.cin = 1'b0;
        ndone = 0;
        bad_pos = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (sif.done) begin
                if (cyc != 8 && cyc != 17 && cyc != 26) bad_pos++;
                if (ndone < 3) begin
                    tests++;
                    if (sif.sum !== exp_res[ndone]) begin
                        fails++;
                        $display("FAIL b2b_sum[%0d]: got %h required %h", ndone, sif.sum, exp_res[ndone]);
                    end
                end
                ndone++;
            end
            if (cyc == 4) begin
                tests++;
                if (sif.sum !== 8'h66) begin fails++; $display("FAIL b2b_hold_prev: got %h required 66", sif.sum); end
            end
            if (cyc == 12) begin
                tests++;
                if (sif.sum !== 8'h03) begin fails++; $display("FAIL b2b_hold_first: got %h required 03", sif.sum); end
            end
            if (cyc == 2)  sif.a = 8'h10;
            if (cyc == 11) sif.a = 8'h20;
            if (cyc == 26) sif.start = 1'b0;
        end
        tests++;
        if (ndone !== 3 || bad_pos !== 0) begin
            fails++;
            $display("FAIL b2b_done_pattern: %0d pulses (%0d misplaced) required 3 at cycles 8/17/26", ndone, bad_pos);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] s, ser;
        logic       c, v, lc;
        int         cyc, nv, ndone;
        @(negedge clk);
        sif.start = 1'b1; sif.a = 8'hFF; sif.b = 8'hFF; sif.sub = 1'b0; sif.cin = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({sif.busy, sif.done, sif.sum, sif.cout, sif.overflow, sif.bit_valid,
             sif.sum_bit, sif.carry_bit} !== 15'h0) begin
            fails++;
            $display("FAIL reset_mid_run_outputs: busy=%b done=%b sum=%h cout=%b ovf=%b bv=%b sb=%b cb=%b required all 0",
                     sif.busy, sif.done, sif.sum, sif.cout, sif.overflow, sif.bit_valid,
                     sif.sum_bit, sif.carry_bit);
        end
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (sif.done) ndone++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (sif.done || sif.busy) ndone++;
        end
        tests++;
        if (ndone !== 0) begin fails++; $display("FAIL reset_mid_run_no_done: activity in %0d cycles required 0", ndone); end
        do_op(8'h12, 8'h34, 1'b0, 1'b0, s, c, v, cyc, nv, ser, lc);
        tests++;
        if ({s, c, v} !== {8'h46, 2'b00}) begin
            fails++;
            $display("FAIL reset_mid_run_fresh: sum=%h cout=%b ovf=%b required 46 0 0", s, c, v);
        end
        tests++;
        if (cyc !== 8) begin fails++; $display("FAIL reset_mid_run_latency: got %0d required 8", cyc); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_add_basic();
        test_add_wrap();
        test_sub();
        test_start_mid_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_adder_fsm.md
# serial_adder_fsm

Parametrised bit-serial adder/subtractor built as a Mealy FSM. It accepts two WIDTH-bit operands with a start pulse and processes one bit per clock, LSB first, holding the carry as state between bits. It presents a registered parallel result with carry-out and signed overflow, plus a per-bit serial monitor. It serves as the multi-bit, mode-selectable generalisation of the team's single-bit adder FSM, for datapaths that trade latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted on a rising edge when busy is 0.
- sub  in  1  mode, sampled with start: 0 computes a + b + cin; 1 computes a - b.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- cin  in  1  carry-in, used in add mode only, sampled with start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse when the result becomes valid.
- sum  out  WIDTH  registered result; holds its value until the next completion.
- cout  out  1  final carry; in sub mode, 1 means no borrow.
- overflow  out  1  signed overflow: carry into the MSB XOR carry out of the MSB.
- bit_valid  out  1  high during each processing cycle.
- sum_bit  out  1  Mealy output: sum bit for the current bit index.
- carry_bit  out  1  Mealy output: carry produced by the current bit.

## Operation
- States:
  - IDLE: start=1 → RUN.
  - RUN: after WIDTH bit cycles → DONE.
  - DONE: start=1 → RUN, otherwise → IDLE.
- Accepting start (in IDLE or DONE):
  - Load operand shift registers with a and (sub ? ~b : b).
  - Carry state ← sub ? 1 : cin.
  - Bit index ← 0.
- RUN, bit i:
  - s = a[i] ^ b'[i] ^ c and c_next = majority(a[i], b'[i], c), computed combinationally.
  - At the edge: s shifts into the result shift register, c ← c_next, index increments.
  - The carry into bit WIDTH-1 is captured for overflow.
- Completion: on the edge committing bit WIDTH-1, sum, cout and overflow are registered together and the state moves to DONE.
- start while busy=1: ignored; operands, mode and cin are not resampled.
- Mealy outputs:
  - bit_valid = (state==RUN).
  - sum_bit = s and carry_bit = c_next when bit_valid is high; both are 0 otherwise.
- Arithmetic: modulo 2^WIDTH. Sub mode is two's-complement (A + ~B + 1). The bit index is a $clog2(WIDTH)-bit counter and does not wrap mid-operation.

## Timing
- Reset (rst_n=0, asynchronous, any state):
  - State ← IDLE.
  - busy, done, sum, cout, overflow, bit_valid, sum_bit, carry_bit all go to 0.
  - Carry state and shift registers clear.
  - An operation interrupted by reset produces no done and leaves no partial result.
- Latency, with start accepted at edge k:
  - busy is high from edge k to edge k+WIDTH.
  - Bit i is committed at edge k+1+i.
  - sum, cout and overflow update at edge k+WIDTH.
  - done is high for exactly the cycle between edges k+WIDTH and k+WIDTH+1.
- Throughput:
  - Back-to-back operation: start held high during the DONE cycle is accepted at edge k+WIDTH+1, giving one result per WIDTH+1 cycles.
  - The previous sum holds until the next completion edge.
- No combinational path from start, a or b to any output. sum_bit and carry_bit depend only on registered state.

## Structure
- Shared package serial_adder_pkg contains:
  - state enum: IDLE, RUN, DONE (2-bit encoding);
  - mode constants MODE_ADD=0, MODE_SUB=1.
- Sub-module full_adder_cell: combinational, 1-bit; inputs a, b, cin; outputs s, cout. Instantiated once.
- The top level holds the FSM, bit counter, operand shift registers, carry register and result registers.

## Test plan
All scenarios use WIDTH=8.
- Add: 8'h3C + 8'h0F, cin=0 → sum 8'h4B, cout 0, overflow 0; done exactly 8 cycles after the accepting edge; bit_valid high for 8 cycles.
- Add wrap and overflow:
  - 8'hFF + 8'h01 → 8'h00, cout 1, overflow 0.
  - 8'h7F + 8'h01 → 8'h80, cout 0, overflow 1.
  - 8'h00 + 8'h00, cin=1 → 8'h01.
- Subtract:
  - 8'h05 - 8'h07 → 8'hFE, cout 0, overflow 0.
  - 8'h80 - 8'h01 → 8'h7F, cout 1, overflow 1.
  - cin is ignored in sub mode.
- start pulsed mid-RUN with different operands → ignored; the original result completes unchanged; exactly one done pulse.
- Back-to-back: start held high continuously → done every 9 cycles; sum holds its previous value between completions.
- rst_n low at bit 4 of a run → all outputs 0 immediately; no done; after release, a fresh 8'h12 + 8'h34 → 8'h46.
